ssm_head_scheduler: RTL and testbench

- Sequences one shared head-level FP16 SSM datapath (ssm_head_fp16) over H heads and T tokens, replacing the fully parallel B*H*P*N top.
- For each (token, head) it issues a start pulse, waits for the datapath's done, captures the P-wide y slice and writes it to the output buffer.
- Signals a state-bank swap at the end of every token.
- Sits between the top-level start/done handshake and the per-head datapath and its h_prev/h_next ping-pong memories.

---
 rtl/ssm_pkg.sv | 19 +
 rtl/ssm_sched_tmo_cnt.sv | 29 ++
 rtl/ssm_head_scheduler.sv | 147 ++++++++++++++
 tb/tb_ssm_head_scheduler.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssm_pkg.sv
// Shared types for the SSM head scheduler: FSM state encoding, FP16 element width,
// and a $clog2 that never returns 0 so single-entry indices still get a 1-bit port.
package ssm_pkg;

  localparam int DW = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_FIN
  } state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ssm_sched_tmo_cnt.sv
// Head-datapath watchdog: cleared on issue, counts WAIT cycles, flags expiry at TMO-1.
// Latency: expire is combinational from the count; no backpressure, saturates at expiry.
// Backpressure: none; the scheduler leaves WAIT on expiry, so the count never advances past TMO-1.
module ssm_sched_tmo_cnt #(
  parameter int TMO = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  import ssm_pkg::*;

  localparam int CW = clog2_min1(TMO);

  logic [CW-1:0] cnt;

  assign expire = (cnt == CW'(TMO - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ssm_head_scheduler.sv
// Sequences one shared FP16 SSM head datapath over H heads x num_tok tokens, writing each y slice.
// Latency: 1 + T*H*(k+2) + 1 cycles per run (k = datapath cycles); SSM_SCHED_PERF_EN adds perf_cyc.
// Backpressure: none; waits on hd_done, gives up after TMO WAIT cycles and flags err.
module ssm_head_scheduler #(
  parameter int H   = 4,
  parameter int P   = 4,
  parameter int DW  = ssm_pkg::DW,
  parameter int TW  = 16,
  parameter int TMO = 1024,
  parameter int HW  = ssm_pkg::clog2_min1(H),
  parameter int AW  = TW + HW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [TW-1:0]   num_tok,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            hd_start,
  output logic [HW-1:0]   hd_idx,
  output logic [TW-1:0]   tok_idx,
  input  logic            hd_done,
  input  logic [P*DW-1:0] hd_y,
  output logic            y_we,
  output logic [AW-1:0]   y_addr,
  output logic [P*DW-1:0] y_data,
  output logic            st_swap
`ifdef SSM_SCHED_PERF_EN
 ,output logic [31:0]     perf_cyc
`endif
);
  import ssm_pkg::*;

  state_t        state, state_nxt;
  logic [TW-1:0] ntok;
  logic          last_hd, last_tok;
  logic          tmo_clr, tmo_en, tmo_exp;

  assign last_hd  = (hd_idx == HW'(H - 1));
  assign last_tok = (tok_idx == ntok - TW'(1));
  assign y_addr   = AW'(tok_idx) * AW'(H) + AW'(hd_idx);

  ssm_sched_tmo_cnt #(.TMO(TMO)) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expire (tmo_exp)
  );

  always_comb begin
    state_nxt = state;
    hd_start  = 1'b0;
    y_we      = 1'b0;
    st_swap   = 1'b0;
    done      = 1'b0;
    tmo_clr   = 1'b0;
    tmo_en    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (num_tok == '0) ? S_FIN : S_ISSUE;
      end
      S_ISSUE: begin
        hd_start  = 1'b1;
        tmo_clr   = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A completion in the expiry cycle still counts as success.
        if (hd_done) begin
          state_nxt = S_WRITE;
        end else begin
          tmo_en = 1'b1;
          if (tmo_exp) state_nxt = S_FIN;
        end
      end
      S_WRITE: begin
        y_we = 1'b1;
        if (last_hd) begin
          st_swap   = 1'b1;
          state_nxt = last_tok ? S_FIN : S_ISSUE;
        end else begin
          state_nxt = S_ISSUE;
        end
      end
      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      err     <= 1'b0;
      ntok    <= '0;
      hd_idx  <= '0;
      tok_idx <= '0;
      y_data  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            ntok    <= num_tok;
            err     <= 1'b0;
            hd_idx  <= '0;
            tok_idx <= '0;
            busy    <= 1'b1;
          end
        end
        S_WAIT: begin
          if (hd_done)      y_data <= hd_y;
          else if (tmo_exp) err    <= 1'b1;
        end
        S_WRITE: begin
          if (last_hd) begin
            hd_idx  <= '0;
            tok_idx <= tok_idx + TW'(1);
          end else begin
            hd_idx  <= hd_idx + HW'(1);
          end
        end
        S_FIN:   busy <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef SSM_SCHED_PERF_EN
  // Run-length counter: zeroed on accept, frozen after done, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cyc <= '0;
    end else if (state == S_IDLE && start) begin
      perf_cyc <= '0;
    end else if (busy && perf_cyc != 32'hFFFF_FFFF) begin
      perf_cyc <= perf_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ssm_head_scheduler.sv
// Randomized scoreboard bench: a run-level model predicts issues, writes, swaps and done timing;
// a responder emulates the head datapath and a monitor checks every DUT event against the queues.
module tb_ssm_head_scheduler;

  localparam int H   = 4;
  localparam int P   = 4;
  localparam int DW  = 16;
  localparam int TW  = 16;
  localparam int TMO = 8;
  localparam int HW  = 2;
  localparam int AW  = TW + HW;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [TW-1:0]   num_tok;
  logic            busy, done, err, hd_start, y_we, st_swap;
  logic [HW-1:0]   hd_idx;
  logic [TW-1:0]   tok_idx;
  logic            hd_done;
  logic [P*DW-1:0] hd_y;
  logic [AW-1:0]   y_addr;
  logic [P*DW-1:0] y_data;

  ssm_head_scheduler #(.H(H), .P(P), .DW(DW), .TW(TW), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .num_tok(num_tok),
    .busy(busy), .done(done), .err(err),
    .hd_start(hd_start), .hd_idx(hd_idx), .tok_idx(tok_idx),
    .hd_done(hd_done), .hd_y(hd_y),
    .y_we(y_we), .y_addr(y_addr), .y_data(y_data), .st_swap(st_swap)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int hd; int tok; } iss_t;
  typedef struct { logic [AW-1:0] addr; logic [P*DW-1:0] data; logic swap; } wr_t;
  typedef struct { logic err; int at; } dn_t;

  iss_t iss_q[$];
  wr_t  wr_q[$];
  dn_t  dn_q[$];

  int checks = 0;
  int errors = 0;

  // Responder knobs
  int k_lat  = 3;
  bit mute   = 0;
  bit spur   = 0;
  bit dbl    = 0;
  int seed   = 0;
  int resp_n = 0;
  int cd     = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] yval(input int s, input int n);
    logic [15:0] a, b;
    a = 16'(s) ^ 16'(n * 257);
    b = 16'(s >> 16) + 16'(n * 3 + 1);
    return {a, b, ~a, a + b};
  endfunction

  // Head datapath model: the n-th completion of a run returns yval(seed, n).
  initial begin
    bit hold;
    hold    = 0;
    hd_done = 1'b0;
    hd_y    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cd      = 0;
        hold    = 0;
        hd_done = 1'b0;
      end else begin
        hd_done = 1'b0;
        if (hold) begin
          hd_done = 1'b1;
          hd_y    = ~hd_y;
          hold    = 0;
        end
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            hd_done = 1'b1;
            hd_y    = yval(seed, resp_n);
            resp_n++;
            hold    = dbl;
          end
        end
        if (hd_start === 1'b1) begin
          if (!mute) cd = k_lat;
          if (spur) begin
            hd_done = 1'b1;
            hd_y    = 64'hDEAD_BEEF_0BAD_F00D;
          end
        end
      end
    end
  end

  // Monitor: every DUT event must match the head of its expectation queue.
  initial begin
    iss_t i;
    wr_t  w;
    dn_t  d;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (hd_start === 1'b1) begin
          if (iss_q.size() == 0) chk("unexpected_hd_start", 1, 0);
          else begin
            i = iss_q.pop_front();
            chk("hd_idx", 64'(hd_idx), 64'(i.hd));
            chk("tok_idx", 64'(tok_idx), 64'(i.tok));
          end
        end
        if (y_we === 1'b1) begin
          if (wr_q.size() == 0) chk("unexpected_y_we", 1, 0);
          else begin
            w = wr_q.pop_front();
            chk("y_addr", 64'(y_addr), 64'(w.addr));
            chk("y_data", y_data, w.data);
            chk("st_swap", 64'(st_swap), 64'(w.swap));
          end
        end else if (st_swap === 1'b1) begin
          chk("st_swap_without_write", 1, 0);
        end
        if (done === 1'b1) begin
          if (dn_q.size() == 0) chk("unexpected_done", 1, 0);
          else begin
            d = dn_q.pop_front();
            chk("done_err", 64'(err), 64'(d.err));
            chk("done_cycle", 64'(cyc), 64'(d.at));
            chk("busy_in_done", 64'(busy), 1);
          end
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},     64'(busy), 0);
    chk({tag, "_done"},     64'(done), 0);
    chk({tag, "_err"},      64'(err), 0);
    chk({tag, "_hd_start"}, 64'(hd_start), 0);
    chk({tag, "_y_we"},     64'(y_we), 0);
    chk({tag, "_st_swap"},  64'(st_swap), 0);
    chk({tag, "_hd_idx"},   64'(hd_idx), 0);
    chk({tag, "_tok_idx"},  64'(tok_idx), 0);
    chk({tag, "_y_addr"},   64'(y_addr), 0);
    chk({tag, "_y_data"},   y_data, 0);
  endtask

  // One run: T tokens, datapath latency k; m = datapath never answers.
  task automatic run(input int T, input int k, input bit m, input bit sp, input bit db, input bit inj);
    int  lat;
    bit  got;
    seed   = int'($urandom);
    resp_n = 0;
    k_lat  = k;
    mute   = m;
    spur   = sp;
    dbl    = db;
    if (m) begin
      if (T > 0) iss_q.push_back('{0, 0});
      lat = (T == 0) ? 1 : 1 + 1 + TMO;
    end else begin
      for (int t = 0; t < T; t++)
        for (int h = 0; h < H; h++) begin
          iss_q.push_back('{h, t});
          wr_q.push_back('{AW'(t * H + h), yval(seed, t * H + h), h == H - 1});
        end
      lat = 1 + T * H * (k + 2);
    end
    @(negedge clk);
    start   = 1'b1;
    num_tok = TW'(T);
    dn_q.push_back('{m && T > 0, cyc + lat});
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 1);
    chk("err_cleared_by_start", 64'(err), 0);
    got = 0;
    for (int i = 0; i < lat + 20; i++) begin
      if (done === 1'b1) begin
        got = 1;
        break;
      end
      // A second start and a different num_tok while busy must change nothing.
      start   = (inj && i == 3);
      num_tok = inj ? TW'(7) : TW'(T);
      @(negedge clk);
    end
    start = 1'b0;
    if (!got) begin
      chk("done_timeout", 0, 1);
      iss_q.delete();
      wr_q.delete();
      dn_q.delete();
    end
    @(negedge clk);
    chk("busy_low_after_done", 64'(busy), 0);
    chk("err_after_done", 64'(err), 64'(m && T > 0));
    chk("issues_left", 64'(iss_q.size()), 0);
    chk("writes_left", 64'(wr_q.size()), 0);
    chk("dones_left", 64'(dn_q.size()), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int T, k;
    bit sp, db;
    rst     = 1'b1;
    start   = 1'b0;
    num_tok = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    run(1, 3, 0, 0, 0, 0);          // basic: 22 cycles start..done inclusive
    run(3, 2, 0, 0, 0, 0);          // 12 writes, swaps after 3, 7, 11
    run(0, 3, 0, 0, 0, 0);          // empty run
    run(1, 3, 1, 0, 0, 0);          // timeout with err
    run(1, 1, 0, 0, 0, 0);          // err cleared by next start
    run(2, TMO, 0, 0, 0, 0);        // hd_done on the expiry cycle wins
    run(2, 4, 0, 1, 1, 1);          // start while busy, spurious and repeated hd_done

    for (int r = 0; r < 6; r++) begin
      T  = $urandom_range(1, 4);
      k  = $urandom_range(1, 6);
      sp = (k >= 2) && ($urandom_range(0, 1) == 1);
      db = ($urandom_range(0, 1) == 1);
      run(T, k, 0, sp, db, T > 1);
    end

    // Reset while waiting on head 2: immediate return to reset values, no done.
    seed   = int'($urandom);
    resp_n = 0;
    k_lat  = 4;
    mute   = 0;
    spur   = 0;
    dbl    = 0;
    for (int h = 0; h < 3; h++) iss_q.push_back('{h, 0});
    for (int h = 0; h < 2; h++) wr_q.push_back('{AW'(h), yval(seed, h), 1'b0});
    @(negedge clk);
    start   = 1'b1;
    num_tok = TW'(1);
    @(negedge clk);
    start = 1'b0;
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
        if (hd_start === 1'b1 && hd_idx == HW'(2)) begin
          seen = 1;
          break;
        end
        @(negedge clk);
      end
      chk("reached_head2", 64'(seen), 1);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("midrun_reset");
    @(negedge clk);
    rst = 1'b0;
    chk("reset_issues_left", 64'(iss_q.size()), 0);
    chk("reset_writes_left", 64'(wr_q.size()), 0);
    iss_q.delete();
    wr_q.delete();
    dn_q.delete();
    repeat (6) @(negedge clk);

    run(2, 3, 0, 0, 0, 0);          // fresh run after reset

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
